// File: rtl/ldtu_frame_decoder.sv
// Receive-side decoder for one LiTE-DTU 32-bit lane: unpacks baseline/signal words
// into a sample stream and checks trailers. Optional error counter: LDTU_DEC_ERRCNT_EN.
module ldtu_frame_decoder #(
    parameter int          Nbits_12  = 12,
    parameter int          Nbits_32  = 32,
    parameter logic [31:0] IDLE_WORD = 32'hEAAAAAAA
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [Nbits_32-1:0] DATA32,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [Nbits_12-1:0] sample,
    output logic                sample_gain,
    output logic                sample_bsl,
    output logic                sample_valid,
    output logic                frame_done,
    output logic                frame_err,
    output logic                hdr_err,
    output logic [15:0]         err_cnt
);

    typedef enum logic {S_IDLE, S_UNPACK} state_t;

    state_t      state, state_nx;
    logic [29:0] shreg, shreg_nx;
    logic        is_bsl, is_bsl_nx;
    logic [2:0]  remain, remain_nx;
    logic [7:0]  frame_cnt, frame_cnt_nx;
    logic        done_nx, ferr_nx, herr_nx;
    logic        accept;
    logic        w_idle, w_base, w_sig, w_trl;

    assign w_idle = (DATA32 == IDLE_WORD);
    assign w_base = !w_idle && (DATA32[31:30] == 2'b01);
    assign w_sig  = !w_idle && (DATA32[31:30] == 2'b10);
    assign w_trl  = !w_idle && (DATA32[31:28] == 4'b1101);

    // Ready again on the cycle the last held sample is shown, so words chain without a bubble.
    assign data_ready = !RST && ((state == S_IDLE) || (remain == 3'd1));
    assign accept     = data_valid && data_ready;

    // The sample currently presented always sits at the bottom of the shift register.
    assign sample       = is_bsl ? {6'b0, shreg[5:0]} : shreg[11:0];
    assign sample_gain  = !is_bsl && shreg[12];
    assign sample_bsl   = is_bsl;
    assign sample_valid = (state == S_UNPACK);

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        is_bsl_nx    = is_bsl;
        remain_nx    = remain;
        frame_cnt_nx = frame_cnt;
        done_nx      = 1'b0;
        ferr_nx      = 1'b0;
        herr_nx      = 1'b0;

        if (state == S_UNPACK) begin
            if (remain != 3'd1) begin
                shreg_nx  = is_bsl ? (shreg >> 6) : (shreg >> 13);
                remain_nx = remain - 3'd1;
            end else begin
                state_nx = S_IDLE;
            end
        end

        if (accept) begin
            if (w_base) begin
                state_nx     = S_UNPACK;
                shreg_nx     = DATA32[29:0];
                is_bsl_nx    = 1'b1;
                remain_nx    = 3'd5;
                frame_cnt_nx = frame_cnt + 8'd5;
            end else if (w_sig) begin
                state_nx     = S_UNPACK;
                shreg_nx     = {4'b0, DATA32[25:0]};
                is_bsl_nx    = 1'b0;
                remain_nx    = 3'd2;
                frame_cnt_nx = frame_cnt + 8'd2;
            end else if (w_trl) begin
                done_nx      = 1'b1;
                ferr_nx      = (frame_cnt != DATA32[27:20]);
                frame_cnt_nx = 8'd0;
            end else if (!w_idle) begin
                herr_nx      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            shreg      <= '0;
            is_bsl     <= 1'b0;
            remain     <= 3'd0;
            frame_cnt  <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            is_bsl     <= is_bsl_nx;
            remain     <= remain_nx;
            frame_cnt  <= frame_cnt_nx;
            frame_done <= done_nx;
            frame_err  <= ferr_nx;
            hdr_err    <= herr_nx;
        end
    end

`ifdef LDTU_DEC_ERRCNT_EN
    logic [15:0] err_q;

    // Counts error pulses one cycle after they appear; saturates rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 16'h0000;
        end else if ((hdr_err || frame_err) && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'h0001;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ldtu_frame_decoder.sv
// Scoreboard bench for ldtu_frame_decoder: driver feeds words and a reference model
// queues expected samples/flags; an independent monitor compares them.
module tb_ldtu_frame_decoder;

    localparam logic [31:0] IDLE_W = 32'hEAAAAAAA;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] DATA32 = 32'h0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [11:0] sample;
    logic        sample_gain, sample_bsl, sample_valid;
    logic        frame_done, frame_err, hdr_err;
    logic [15:0] err_cnt;

    ldtu_frame_decoder dut (
        .CLK(CLK), .RST(RST), .DATA32(DATA32), .data_valid(data_valid),
        .data_ready(data_ready), .sample(sample), .sample_gain(sample_gain),
        .sample_bsl(sample_bsl), .sample_valid(sample_valid), .frame_done(frame_done),
        .frame_err(frame_err), .hdr_err(hdr_err), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {int cyc; logic [11:0] val; logic gain; logic bsl;} samp_t;
    typedef struct {int cyc; logic [2:0] flags;} flag_t;

    samp_t samp_q[$];
    flag_t flag_q[$];
    int    errinc_q[$];

    int cyc = 0;
    int checks = 0;
    int passed = 0;
    int frame_total = 0;
    int last_busy = 0;
    int err_model = 0;
    samp_t mon_s;
    logic [2:0] mon_flags;

    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        else
            passed++;
    endtask

    // Reference model: turns one accepted word into the samples and pulses it must produce.
    task automatic refModel(input logic [31:0] w);
        samp_t s;
        flag_t f;
        if (w == IDLE_W) begin
        end else if (w[31:30] == 2'b01) begin
            for (int i = 0; i < 5; i++) begin
                s.cyc  = cyc + 1 + i;
                s.val  = 12'((w >> (6 * i)) & 32'h3F);
                s.gain = 1'b0;
                s.bsl  = 1'b1;
                samp_q.push_back(s);
            end
            frame_total += 5;
            last_busy = cyc + 5;
        end else if (w[31:30] == 2'b10) begin
            for (int i = 0; i < 2; i++) begin
                s.cyc  = cyc + 1 + i;
                s.val  = 12'((w >> (13 * i)) & 32'hFFF);
                s.gain = 1'(((w >> (13 * i + 12)) & 32'h1));
                s.bsl  = 1'b0;
                samp_q.push_back(s);
            end
            frame_total += 2;
            last_busy = cyc + 2;
        end else if (w[31:28] == 4'hD) begin
            f.cyc   = cyc + 1;
            f.flags = {1'b1, (frame_total % 256) != int'(w[27:20]), 1'b0};
            flag_q.push_back(f);
            if (f.flags[1]) errinc_q.push_back(cyc + 2);
            frame_total = 0;
        end else begin
            f.cyc   = cyc + 1;
            f.flags = 3'b001;
            flag_q.push_back(f);
            errinc_q.push_back(cyc + 2);
        end
    endtask

    // One clock of driving: check handshake readiness, feed the model on accept.
    task automatic driveCycle(output bit acc);
        @(negedge CLK);
        checkOutput("data_ready", 32'(data_ready), 32'(!RST && (cyc >= last_busy)));
        acc = data_valid && data_ready;
        if (acc) refModel(DATA32);
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        bit acc;
        acc = 1'b0;
        DATA32 = w;
        data_valid = 1'b1;
        for (int t = 0; t < 30 && !acc; t++) driveCycle(acc);
        if (!acc) begin
            checks++;
            $display("[TB] FAIL accept_timeout word %08h: got no accept, expected accept within 30 cycles", w);
        end
        data_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        data_valid = 1'b0;
        DATA32 = $urandom;
        for (int i = 0; i < n; i++) driveCycle(acc);
    endtask

    task automatic resetDut();
        bit acc;
        RST = 1'b1;
        data_valid = 1'b0;
        last_busy = 0;
        frame_total = 0;
        driveCycle(acc);
        driveCycle(acc);
        @(negedge CLK);
        checkOutput("rst_sample", 32'(sample), 32'h0);
        checkOutput("rst_gain_bsl", 32'({sample_gain, sample_bsl}), 32'h0);
        checkOutput("rst_sample_valid", 32'(sample_valid), 32'h0);
        checkOutput("rst_flags", 32'({frame_done, frame_err, hdr_err}), 32'h0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("rst_ready", 32'(data_ready), 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge CLK) begin
        if (RST) begin
            samp_q.delete();
            flag_q.delete();
            errinc_q.delete();
            err_model = 0;
        end else begin
            while (errinc_q.size() > 0 && errinc_q[0] <= cyc) begin
                void'(errinc_q.pop_front());
                if (err_model < 65535) err_model++;
            end
            if (sample_valid) begin
                if (samp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_sample at cycle %0d: got sample %0h, expected none", cyc, sample);
                end else begin
                    mon_s = samp_q.pop_front();
                    checkOutput("sample_cycle", 32'(cyc), 32'(mon_s.cyc));
                    checkOutput("sample_value", 32'({sample_gain, sample_bsl, sample}),
                                32'({mon_s.gain, mon_s.bsl, mon_s.val}));
                end
            end else if (samp_q.size() > 0 && samp_q[0].cyc <= cyc) begin
                mon_s = samp_q.pop_front();
                checks++;
                $display("[TB] FAIL missing_sample at cycle %0d: got no sample_valid, expected sample %0h", cyc, mon_s.val);
            end
            mon_flags = 3'b000;
            if (flag_q.size() > 0 && flag_q[0].cyc == cyc) mon_flags = flag_q.pop_front().flags;
            checkOutput("flags{done,ferr,herr}", 32'({frame_done, frame_err, hdr_err}), 32'(mon_flags));
`ifdef LDTU_DEC_ERRCNT_EN
            checkOutput("err_cnt", 32'(err_cnt), 32'(err_model));
`else
            checkOutput("err_cnt", 32'(err_cnt), 32'h0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int r;
        @(posedge CLK);
        #1;
        resetDut();

        $display("[TB] idle stream");
        for (int i = 0; i < 8; i++) applyStimulus(IDLE_W);

        $display("[TB] baseline word 1..5");
        applyStimulus({2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
        idleCycles(6);

        $display("[TB] back-to-back signal words");
        applyStimulus({2'b10, 4'h0, 13'h0123, 13'h1ABC});
        applyStimulus({2'b10, 4'h5, 13'h1ABC, 13'h0123});
        applyStimulus({4'hD, 8'd9, 20'h0});
        idleCycles(3);

        $display("[TB] frame trailer checks");
        for (int k = 0; k < 2; k++) begin
            applyStimulus({2'b01, 30'($urandom)});
            applyStimulus({2'b01, 30'($urandom)});
            applyStimulus({2'b10, 30'($urandom)});
            applyStimulus({4'hD, (k == 0) ? 8'd12 : 8'd11, 20'hABCDE});
            idleCycles(3);
        end

        $display("[TB] unknown header");
        applyStimulus(32'h0000_0000);
        applyStimulus({4'hD, 8'd0, 20'h0});
        idleCycles(3);

        $display("[TB] frame counter wrap");
        for (int i = 0; i < 60; i++) applyStimulus({2'b01, 30'($urandom)});
        applyStimulus({4'hD, 8'd44, 20'h0});
        idleCycles(3);

        $display("[TB] reset during unpack");
        applyStimulus({2'b01, 30'($urandom)});
        idleCycles(1);
        resetDut();
        idleCycles(4);
        applyStimulus({4'hD, 8'd0, 20'h0});
        idleCycles(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: applyStimulus(IDLE_W);
                1, 2, 3: applyStimulus({2'b01, 30'($urandom)});
                4, 5, 6: applyStimulus({2'b10, 30'($urandom)});
                7: begin
                    w = $urandom;
                    w[31:28] = 4'hD;
                    if ($urandom_range(0, 1) == 1) w[27:20] = 8'(frame_total % 256);
                    applyStimulus(w);
                end
                8: begin
                    w = $urandom;
                    case ($urandom_range(0, 3))
                        0: w[31:30] = 2'b00;
                        1: w[31:28] = 4'hC;
                        2: w[31:28] = 4'hE;
                        default: w[31:28] = 4'hF;
                    endcase
                    if (w == IDLE_W) w[0] = 1'b1;
                    applyStimulus(w);
                end
                default: idleCycles($urandom_range(1, 3));
            endcase
        end
        idleCycles(8);

        checkOutput("sample_queue_drained", 32'(samp_q.size()), 32'h0);
        checkOutput("flag_queue_drained", 32'(flag_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
